// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: FSM states, access sizes
// and the request legality rule used at accept time.
package mem_access_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        MREQ  = 4'b0010,
        MRESP = 4'b0100,
        CRESP = 4'b1000
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Misaligned accesses and doublewords on a 32-bit bus never reach memory.
    function automatic logic is_illegal(input size_e size, input logic [2:0] addr_lo,
                                        input int unsigned data_w);
        case (size)
            SZ_B:    is_illegal = 1'b0;
            SZ_H:    is_illegal = addr_lo[0];
            SZ_W:    is_illegal = |addr_lo[1:0];
            default: is_illegal = (|addr_lo) || (data_w == 32);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core and the memory bus: store strobes and
// replicated store data, plus load lane extraction with sign/zero extension.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  size_e                          size,
    input  logic [$clog2(DATA_W/8)-1:0]    offset,
    input  logic                           zero_ext,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [DATA_W-1:0]              rdata,
    output logic [DATA_W/8-1:0]            strb,
    output logic [DATA_W-1:0]              wdata_rep,
    output logic [DATA_W-1:0]              rdata_ext
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] shifted;
    logic              sign;

    always_comb begin : align
        int unsigned off;
        int unsigned nbytes;
        int unsigned nbits;

        off    = 32'(offset);
        nbytes = 32'd1 << size;
        nbits  = (8 * nbytes > DATA_W) ? DATA_W : 8 * nbytes;

        strb = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            strb[i] = (i >= off) && (i < off + nbytes);
        end

        wdata_rep = '0;
        case (size)
            SZ_B: for (int unsigned i = 0; i < NB; i++)     wdata_rep[8*i +: 8]   = wdata[7:0];
            SZ_H: for (int unsigned i = 0; i < NB / 2; i++) wdata_rep[16*i +: 16] = wdata[15:0];
            SZ_W: for (int unsigned i = 0; i < NB / 4; i++) wdata_rep[32*i +: 32] = wdata[31:0];
            default: wdata_rep = wdata;
        endcase

        // Bring the addressed lane down to bit 0, then extend above its width.
        shifted = rdata >> (8 * off);
        sign    = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) sign = shifted[i] & ~zero_ext;
        end
        rdata_ext = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            rdata_ext[i] = (i < nbits) ? shifted[i] : sign;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Core-to-memory access unit: one outstanding load/store, legality check at
// accept, lane alignment, and load/store/stall/error performance counters.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   Address,
    output logic                MemRead,
    output logic                MemWrite,
    output logic [DATA_W-1:0]   Write_data,
    output logic [DATA_W/8-1:0] Write_strb,
    input  logic                Mem_Req_Ready,
    input  logic [DATA_W-1:0]   Read_data,
    input  logic                Read_data_Valid,
    output logic                Read_data_Ready,
    output logic [CNT_W-1:0]    load_cnt,
    output logic [CNT_W-1:0]    store_cnt,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int unsigned      NB         = DATA_W / 8;
    localparam int unsigned      OFF_W      = $clog2(NB);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);

    state_e              state;
    logic                write_q;
    logic                zero_ext_q;
    size_e               size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_ext;
    logic                illegal;

    assign illegal = is_illegal(size_e'(req_size), req_addr[2:0], DATA_W);
    assign Address = addr_q & ALIGN_MASK;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size      (size_q),
        .offset    (addr_q[OFF_W-1:0]),
        .zero_ext  (zero_ext_q),
        .wdata     (wdata_q),
        .rdata     (Read_data),
        .strb      (Write_strb),
        .wdata_rep (Write_data),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            MemRead         <= 1'b0;
            MemWrite        <= 1'b0;
            Read_data_Ready <= 1'b0;
            resp_valid      <= 1'b0;
            resp_err        <= 1'b0;
            resp_rdata      <= '0;
            write_q         <= 1'b0;
            zero_ext_q      <= 1'b0;
            size_q          <= SZ_B;
            addr_q          <= '0;
            wdata_q         <= '0;
            load_cnt        <= '0;
            store_cnt       <= '0;
            stall_cnt       <= '0;
            err_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q    <= req_write;
                        zero_ext_q <= req_unsigned;
                        size_q     <= size_e'(req_size);
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        if (illegal) begin
                            state      <= CRESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            err_cnt    <= err_cnt + CNT_W'(1);
                        end else begin
                            state    <= MREQ;
                            MemRead  <= ~req_write;
                            MemWrite <= req_write;
                        end
                    end
                end
                MREQ: begin
                    if (Mem_Req_Ready) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        if (write_q) begin
                            state      <= CRESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                            store_cnt  <= store_cnt + CNT_W'(1);
                        end else begin
                            state           <= MRESP;
                            Read_data_Ready <= 1'b1;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                MRESP: begin
                    if (Read_data_Valid) begin
                        state           <= CRESP;
                        Read_data_Ready <= 1'b0;
                        resp_valid      <= 1'b1;
                        resp_err        <= 1'b0;
                        resp_rdata      <= rdata_ext;
                        load_cnt        <= load_cnt + CNT_W'(1);
                    end else begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                CRESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    req_ready       <= 1'b1;
                    MemRead         <= 1'b0;
                    MemWrite        <= 1'b0;
                    Read_data_Ready <= 1'b0;
                    resp_valid      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit (4-bit counters) and a 64-bit instance
// share stimulus; a transaction-level model supplies every expected value.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0, Read_data = '0;
    logic        resp_ready = 1'b0, Mem_Req_Ready = 1'b0, Read_data_Valid = 1'b0;
    logic        rv32_in, rv64_in;

    logic        r32_req_ready, r32_rv, r32_err, r32_mr, r32_mw, r32_rdr;
    logic [31:0] r32_rdata, r32_addr, r32_wdata;
    logic [3:0]  r32_strb;
    logic [3:0]  c32_ld, c32_st, c32_stall, c32_err;

    logic        r64_req_ready, r64_rv, r64_err, r64_mr, r64_mw, r64_rdr;
    logic [63:0] r64_rdata, r64_wdata;
    logic [31:0] r64_addr;
    logic [7:0]  r64_strb;
    logic [31:0] c64_ld, c64_st, c64_stall, c64_err;

    logic        v_req_ready, v_rv, v_err, v_mr, v_mw, v_rdr, o_busy;
    logic [63:0] v_rdata, v_wdata;
    logic [31:0] v_addr;
    logic [7:0]  v_strb;

    logic        chk_en = 1'b0;
    logic        exp_wr = 1'b0, exp_err = 1'b0;
    logic [63:0] exp_rdata = '0, exp_wdata = '0;
    logic [31:0] exp_addr = '0;
    logic [7:0]  exp_strb = '0;

    logic [63:0] last_rdata = '0, last_wdata = '0;
    logic [31:0] last_addr = '0;
    logic [7:0]  last_strb = '0;
    logic        last_err = 1'b0;
    int          last_lat = 0;

    int unsigned m_ld[2], m_st[2], m_stall[2], m_err[2];
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    assign rv32_in = req_valid & ~sel;
    assign rv64_in = req_valid & sel;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .CNT_W(4)) u32 (
        .clk(clk), .rst(rst), .req_valid(rv32_in), .req_ready(r32_req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(r32_rv), .resp_ready(resp_ready & ~sel), .resp_rdata(r32_rdata), .resp_err(r32_err),
        .Address(r32_addr), .MemRead(r32_mr), .MemWrite(r32_mw), .Write_data(r32_wdata),
        .Write_strb(r32_strb), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data(Read_data[31:0]), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(r32_rdr),
        .load_cnt(c32_ld), .store_cnt(c32_st), .stall_cnt(c32_stall), .err_cnt(c32_err)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .CNT_W(32)) u64 (
        .clk(clk), .rst(rst), .req_valid(rv64_in), .req_ready(r64_req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r64_rv), .resp_ready(resp_ready & sel), .resp_rdata(r64_rdata), .resp_err(r64_err),
        .Address(r64_addr), .MemRead(r64_mr), .MemWrite(r64_mw), .Write_data(r64_wdata),
        .Write_strb(r64_strb), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(r64_rdr),
        .load_cnt(c64_ld), .store_cnt(c64_st), .stall_cnt(c64_stall), .err_cnt(c64_err)
    );

    always_comb begin
        if (sel) begin
            v_req_ready = r64_req_ready; v_rv = r64_rv; v_err = r64_err;
            v_mr = r64_mr; v_mw = r64_mw; v_rdr = r64_rdr;
            v_rdata = r64_rdata; v_wdata = r64_wdata; v_addr = r64_addr; v_strb = r64_strb;
            o_busy = r32_rv | r32_mr | r32_mw | r32_rdr;
        end else begin
            v_req_ready = r32_req_ready; v_rv = r32_rv; v_err = r32_err;
            v_mr = r32_mr; v_mw = r32_mw; v_rdr = r32_rdr;
            v_rdata = 64'(r32_rdata); v_wdata = 64'(r32_wdata); v_addr = r32_addr; v_strb = 8'(r32_strb);
            o_busy = r64_rv | r64_mr | r64_mw | r64_rdr;
        end
    end

    // Transaction-level expectations from byte arithmetic on the request.
    function automatic bit m_illegal(input int dw, input logic [31:0] a, input logic [1:0] sz);
        int nb;
        nb = 1 << sz;
        return ((a % nb) != 0) || (nb == 8 && dw == 32);
    endfunction

    function automatic logic [63:0] m_load(input int dw, input logic [31:0] a, input logic [1:0] sz,
                                           input bit uns, input logic [63:0] rd);
        logic [63:0] v;
        int nb, lane;
        nb = 1 << sz;
        lane = int'(a % (dw / 8));
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(lane+i) +: 8];
        if (!uns && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        if (dw == 32) v[63:32] = '0;
        return v;
    endfunction

    function automatic logic [7:0] m_strb(input int dw, input logic [31:0] a, input logic [1:0] sz);
        int nb;
        nb = 1 << sz;
        return 8'((1 << nb) - 1) << (a % (dw / 8));
    endfunction

    function automatic logic [63:0] m_wdata(input int dw, input logic [1:0] sz, input logic [63:0] wd);
        logic [63:0] v;
        int nb;
        nb = 1 << sz;
        v = '0;
        for (int i = 0; i < dw / 8; i++) v[8*i +: 8] = wd[8*(i % nb) +: 8];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters();
        chk("u32 load_cnt",  64'(c32_ld),    64'(m_ld[0] % 16));
        chk("u32 store_cnt", 64'(c32_st),    64'(m_st[0] % 16));
        chk("u32 stall_cnt", 64'(c32_stall), 64'(m_stall[0] % 16));
        chk("u32 err_cnt",   64'(c32_err),   64'(m_err[0] % 16));
        chk("u64 load_cnt",  64'(c64_ld),    64'(m_ld[1]));
        chk("u64 store_cnt", 64'(c64_st),    64'(m_st[1]));
        chk("u64 stall_cnt", 64'(c64_stall), 64'(m_stall[1]));
        chk("u64 err_cnt",   64'(c64_err),   64'(m_err[1]));
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (v_rv) begin
                    chk("resp_err", 64'(v_err), 64'(exp_err));
                    chk("resp_rdata", v_rdata, exp_rdata);
                    chk("req_ready low while responding", 64'(v_req_ready), 64'(0));
                    last_rdata = v_rdata;
                    last_err   = v_err;
                end
                if (exp_err) begin
                    chk("no memory access on error", 64'({v_mr, v_mw}), 64'(0));
                end else if (v_mr || v_mw) begin
                    chk("MemRead", 64'(v_mr), 64'(!exp_wr));
                    chk("MemWrite", 64'(v_mw), 64'(exp_wr));
                    chk("Address", 64'(v_addr), 64'(exp_addr));
                    if (exp_wr) begin
                        chk("Write_strb", 64'(v_strb), 64'(exp_strb));
                        chk("Write_data", v_wdata, exp_wdata);
                    end
                    last_addr  = v_addr;
                    last_strb  = v_strb;
                    last_wdata = v_wdata;
                end
                chk("unselected unit quiet", 64'(o_busy), 64'(0));
            end
        end
    endtask

    // One request on unit d: md/rdl stall cycles on the memory side, cd cycles of
    // response back-pressure, noise drives ready/valid pulses where they must be ignored.
    task automatic xact(input bit d, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int md, input int rdl, input int cd, input bit noise);
        int  dw, lat, exp_lat, mwait, rwait, t;
        bit  err;
        dw  = d ? 64 : 32;
        err = m_illegal(dw, a, sz);
        exp_wr    = wr;
        exp_err   = err;
        exp_rdata = (err || wr) ? 64'(0) : m_load(dw, a, sz, uns, rd);
        exp_addr  = a & ~32'(dw / 8 - 1);
        exp_strb  = m_strb(dw, a, sz);
        exp_wdata = m_wdata(dw, sz, wd);
        sel = d; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        #1;
        t = 0;
        while (!v_req_ready && t < 20) begin tick(); t++; end
        chk("req_ready before accept", 64'(v_req_ready), 64'(1));
        tick();
        req_valid = 1'b0;

        lat = 1; mwait = 0; rwait = 0;
        while (!v_rv && lat < 60) begin
            Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0; Read_data = 64'hDEAD_BEEF_0BAD_F00D;
            if (v_mr || v_mw) begin
                if (mwait == md) Mem_Req_Ready = 1'b1; else mwait++;
            end else if (noise) Mem_Req_Ready = 1'b1;
            if (v_rdr) begin
                if (rwait == rdl) begin Read_data_Valid = 1'b1; Read_data = rd; end
                else rwait++;
            end else if (noise) Read_data_Valid = 1'b1;
            tick();
            lat++;
        end
        Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0;
        exp_lat = err ? 1 : (wr ? 2 + md : 3 + md + rdl);
        chk("accept-to-resp latency", 64'(lat), 64'(exp_lat));
        last_lat = lat;

        for (int i = 0; i < cd; i++) begin
            Mem_Req_Ready = noise; Read_data_Valid = noise;
            tick();
        end
        Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        if (err) m_err[d]++;
        else if (wr) m_st[d]++;
        else m_ld[d]++;
        if (!err) m_stall[d] += md + (wr ? 0 : rdl);
        chk_counters();
        chk("req_ready after response", 64'(v_req_ready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        fork
            compare_loop();
        join_none
        for (int i = 0; i < 2; i++) begin m_ld[i] = 0; m_st[i] = 0; m_stall[i] = 0; m_err[i] = 0; end

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset req_ready u32", 64'(r32_req_ready), 64'(1));
        chk("reset req_ready u64", 64'(r64_req_ready), 64'(1));
        chk("reset outputs u32", 64'({r32_mr, r32_mw, r32_rdr, r32_rv}), 64'(0));
        chk("reset outputs u64", 64'({r64_mr, r64_mw, r64_rdr, r64_rv}), 64'(0));
        chk_counters();
        chk_en = 1'b1;

        // Word load, immediate memory
        xact(0, 0, 2'd2, 0, 32'h104, 64'h0, 64'h8000_00F0, 0, 0, 0, 0);
        chk("LW rdata", last_rdata, 64'h8000_00F0);
        chk("LW latency", 64'(last_lat), 64'(3));
        chk("LW load_cnt", 64'(c32_ld), 64'(1));

        // LB then LBU on the top lane
        xact(0, 0, 2'd0, 0, 32'h103, 64'h0, 64'h9A00_0000, 0, 0, 0, 0);
        chk("LB rdata", last_rdata, 64'hFFFF_FF9A);
        xact(0, 0, 2'd0, 1, 32'h103, 64'h0, 64'h9A00_0000, 0, 0, 1, 1);
        chk("LBU rdata", last_rdata, 64'h0000_009A);

        // SH with four stall cycles
        xact(0, 1, 2'd1, 0, 32'h202, 64'h1234, 64'h0, 4, 0, 2, 1);
        chk("SH Address", 64'(last_addr), 64'h200);
        chk("SH Write_strb", 64'(last_strb), 64'hC);
        chk("SH Write_data", last_wdata, 64'h1234_1234);
        chk("SH stall_cnt", 64'(c32_stall), 64'(4));
        chk("SH store_cnt", 64'(c32_st), 64'(1));
        chk("SH latency", 64'(last_lat), 64'(6));

        // Illegal requests
        xact(0, 0, 2'd2, 0, 32'h101, 64'h0, 64'h0, 0, 0, 0, 1);
        chk("misaligned resp_err", 64'(last_err), 64'(1));
        chk("misaligned latency", 64'(last_lat), 64'(1));
        chk("misaligned err_cnt", 64'(c32_err), 64'(1));
        xact(0, 0, 2'd3, 0, 32'h100, 64'h0, 64'h0, 0, 0, 0, 0);
        chk("dword on 32-bit err_cnt", 64'(c32_err), 64'(2));

        // 64-bit unit
        xact(1, 0, 2'd2, 1, 32'h1004, 64'h0, 64'hFFFF_FFFF_0000_0001, 0, 0, 0, 0);
        chk("LWU Address", 64'(last_addr), 64'h1000);
        chk("LWU rdata", last_rdata, 64'h0000_0000_FFFF_FFFF);
        xact(1, 0, 2'd3, 0, 32'h2008, 64'h0, 64'h8123_4567_89AB_CDEF, 1, 2, 0, 1);
        chk("LD rdata", last_rdata, 64'h8123_4567_89AB_CDEF);
        xact(1, 0, 2'd1, 0, 32'h2006, 64'h0, 64'h8001_0000_0000_0000, 0, 1, 0, 0);
        chk("LH rdata", last_rdata, 64'hFFFF_FFFF_FFFF_8001);
        xact(1, 1, 2'd0, 0, 32'h2005, 64'hAB, 64'h0, 2, 0, 0, 1);
        chk("SB64 Write_strb", 64'(last_strb), 64'h20);
        chk("SB64 Write_data", last_wdata, 64'hABAB_ABAB_ABAB_ABAB);
        xact(1, 1, 2'd3, 0, 32'h3000, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0, 0);
        xact(1, 1, 2'd2, 0, 32'h3006, 64'h0, 64'h0, 0, 0, 0, 0);

        // More 32-bit shapes
        xact(0, 1, 2'd2, 0, 32'h300, 64'hCAFE_F00D, 64'h0, 0, 0, 3, 1);
        xact(0, 0, 2'd1, 1, 32'h102, 64'h0, 64'hF00D_1234, 2, 3, 0, 1);
        chk("LHU rdata", last_rdata, 64'h0000_F00D);

        // err_cnt wraps on the 4-bit counters: 2 + 15 = 17
        for (int i = 0; i < 15; i++) xact(0, 0, 2'd1, 0, 32'h301, 64'h0, 64'h0, 0, 0, 0, 0);
        chk("err_cnt wrap", 64'(c32_err), 64'(1));

        // Reset while waiting for read data
        chk_en = 1'b0;
        sel = 1'b0; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h100; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; Mem_Req_Ready = 1'b1;
        tick();
        Mem_Req_Ready = 1'b0;
        chk("reset test reaches read wait", 64'(r32_rdr), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("async reset outputs", 64'({r32_mr, r32_mw, r32_rdr, r32_rv}), 64'(0));
        chk("async reset req_ready", 64'(r32_req_ready), 64'(1));
        for (int i = 0; i < 2; i++) begin m_ld[i] = 0; m_st[i] = 0; m_stall[i] = 0; m_err[i] = 0; end
        chk_counters();
        Read_data = 64'h1111_2222; Read_data_Valid = 1'b1;
        tick();
        Read_data_Valid = 1'b0;
        rst = 1'b1;
        chk("req_ready first cycle after release", 64'(r32_req_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            Read_data_Valid = 1'b1;
            tick();
            Read_data_Valid = 1'b0;
            chk("no response after reset", 64'({r32_rv, r32_rdr}), 64'(0));
        end
        chk_counters();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
